// File: rtl/icache_pkg.sv
// Shared definitions for the two-way instruction cache: FSM encodings, read-enable pattern, log2 helper.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } state_t;

    localparam logic [3:0] MEM_REN_ALL = 4'hF;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and data block; combinational read, synchronous write.
// Flush clears every valid bit and takes priority over a same-cycle write.
module icache_way #(
    parameter int BLK_LEN = 4,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   we_i,
    input  logic [INDEX_W-1:0]     idx_i,
    input  logic [TAG_W-1:0]       wtag_i,
    input  logic [BLK_LEN*32-1:0]  wdata_i,
    output logic                   rvalid_o,
    output logic [TAG_W-1:0]       rtag_o,
    output logic [BLK_LEN*32-1:0]  rdata_o
);
    localparam int SETS = 1 << INDEX_W;

    logic [SETS-1:0]         valid_q;
    logic [TAG_W-1:0]        tag_q  [SETS];
    logic [BLK_LEN*32-1:0]   data_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tag/data storage carries no reset: contents are meaningless while valid is low.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[idx_i]  <= wtag_i;
            data_q[idx_i] <= wdata_i;
        end
    end

    assign rvalid_o = valid_q[idx_i];
    assign rtag_o   = tag_q[idx_i];
    assign rdata_o  = data_q[idx_i];

endmodule

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache, LRU replacement; hit latency 2 cycles from rreq, miss waits on mem_rrdy/mem_rvalid.
// Performance counters exist only when ICACHE_PERF_EN is defined; otherwise they read constant 0.
module icache_2way
    import icache_pkg::*;
#(
    parameter int BLK_LEN = 4,
    parameter int INDEX_W = 6
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst_n,
    input  logic                   inst_rreq,
    input  logic [31:0]            inst_addr,
    input  logic                   inst_flush,
    output logic                   inst_valid,
    output logic [31:0]            inst_out,
    input  logic                   mem_rrdy,
    output logic [3:0]             mem_ren,
    output logic [31:0]            mem_raddr,
    input  logic                   mem_rvalid,
    input  logic [BLK_LEN*32-1:0]  mem_rdata,
    output logic [31:0]            perf_hit_cnt,
    output logic [31:0]            perf_miss_cnt
);
    localparam int OFF_W  = clog2(BLK_LEN) + 2;
    localparam int TAG_W  = 32 - INDEX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int SETS   = 1 << INDEX_W;

    state_t                 state_q;
    logic [31:0]            req_addr_q;
    logic                   inst_valid_q;
    logic [31:0]            inst_out_q;
    logic [3:0]             mem_ren_q;
    logic [31:0]            mem_raddr_q;
    logic [SETS-1:0]        lru_q, lru_d;

    logic [INDEX_W-1:0]     idx;
    logic [TAG_W-1:0]       tag;
    logic [WSEL_W-1:0]      wsel;
    logic [31:0]            blk_addr;
    logic                   v0, v1, hit0, hit1, lookup_hit;
    logic [TAG_W-1:0]       t0, t1;
    logic [BLK_LEN*32-1:0]  d0, d1, hit_blk;
    logic [31:0]            hit_word, fill_word;
    logic                   victim_way, refill_we;
    logic                   unused_addr_bits;

    assign idx      = req_addr_q[OFF_W +: INDEX_W];
    assign tag      = req_addr_q[31 -: TAG_W];
    assign wsel     = req_addr_q[2 +: WSEL_W];
    assign blk_addr = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
    assign unused_addr_bits = ^req_addr_q[1:0];

    assign hit0       = v0 && (t0 == tag);
    assign hit1       = v1 && (t1 == tag);
    assign lookup_hit = (hit0 || hit1) && !inst_flush;
    assign hit_blk    = hit1 ? d1 : d0;

    assign victim_way = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[idx]);
    // A flush landing with the returning block still forwards the data but must not leave a valid line.
    assign refill_we  = (state_q == ST_REFILL) && mem_rvalid && !inst_flush;

    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int i = 0; i < BLK_LEN; i++) begin
            if (wsel == i[WSEL_W-1:0]) begin
                hit_word  = hit_blk[i*32 +: 32];
                fill_word = mem_rdata[i*32 +: 32];
            end
        end
    end

    icache_way #(.BLK_LEN(BLK_LEN), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way0 (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .flush_i  (inst_flush),
        .we_i     (refill_we && !victim_way),
        .idx_i    (idx),
        .wtag_i   (tag),
        .wdata_i  (mem_rdata),
        .rvalid_o (v0),
        .rtag_o   (t0),
        .rdata_o  (d0)
    );

    icache_way #(.BLK_LEN(BLK_LEN), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_way1 (
        .clk      (cpu_clk),
        .rst_n    (cpu_rst_n),
        .flush_i  (inst_flush),
        .we_i     (refill_we && victim_way),
        .idx_i    (idx),
        .wtag_i   (tag),
        .wdata_i  (mem_rdata),
        .rvalid_o (v1),
        .rtag_o   (t1),
        .rdata_o  (d1)
    );

    always_comb begin
        lru_d = lru_q;
        if (inst_flush) begin
            lru_d = '0;
        end else if (state_q == ST_LOOKUP && lookup_hit) begin
            lru_d[idx] = !hit1;
        end else if (refill_we) begin
            lru_d[idx] = !victim_way;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            lru_q <= '0;
        end else begin
            lru_q <= lru_d;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q      <= ST_IDLE;
            req_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            mem_ren_q    <= '0;
            mem_raddr_q  <= '0;
        end else begin
            inst_valid_q <= 1'b0;
            mem_ren_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (inst_rreq) begin
                        req_addr_q <= inst_addr;
                        state_q    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_hit) begin
                        inst_valid_q <= 1'b1;
                        inst_out_q   <= hit_word;
                        state_q      <= ST_IDLE;
                    end else begin
                        state_q <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mem_rrdy) begin
                        mem_ren_q   <= MEM_REN_ALL;
                        mem_raddr_q <= blk_addr;
                        state_q     <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_rvalid) begin
                        inst_valid_q <= 1'b1;
                        inst_out_q   <= fill_word;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign mem_ren    = mem_ren_q;
    assign mem_raddr  = mem_raddr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (lookup_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`else
    assign perf_hit_cnt  = '0;
    assign perf_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: default geometry plus a BLK_LEN=8/INDEX_W=4 instance sharing the CPU-side inputs.
module tb_icache_2way;

`ifdef ICACHE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n, rreq, flush, rrdy, rvalid;
    logic [31:0]  addr;
    logic [127:0] a_rdata;
    logic [255:0] b_rdata;

    logic         a_valid, b_valid;
    logic [31:0]  a_out, b_out, a_raddr, b_raddr;
    logic [3:0]   a_ren, b_ren;
    logic [31:0]  a_hit, a_miss, b_hit, b_miss;

    int checks   = 0;
    int failures = 0;
    int exp_h    = 0;
    int exp_m    = 0;
    logic [31:0] exp_raddr = '0;

    always #5 clk = ~clk;

    icache_2way #(.BLK_LEN(4), .INDEX_W(6)) dut_a (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .inst_rreq(rreq), .inst_addr(addr),
        .inst_flush(flush), .inst_valid(a_valid), .inst_out(a_out),
        .mem_rrdy(rrdy), .mem_ren(a_ren), .mem_raddr(a_raddr),
        .mem_rvalid(rvalid), .mem_rdata(a_rdata),
        .perf_hit_cnt(a_hit), .perf_miss_cnt(a_miss)
    );

    icache_2way #(.BLK_LEN(8), .INDEX_W(4)) dut_b (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .inst_rreq(rreq), .inst_addr(addr),
        .inst_flush(flush), .inst_valid(b_valid), .inst_out(b_out),
        .mem_rrdy(rrdy), .mem_ren(b_ren), .mem_raddr(b_raddr),
        .mem_rvalid(rvalid), .mem_rdata(b_rdata),
        .perf_hit_cnt(b_hit), .perf_miss_cnt(b_miss)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [255:0] mk_block(input logic [31:0] base, input int n);
        logic [255:0] blk;
        blk = '0;
        for (int i = 0; i < n; i++) blk[i*32 +: 32] = memword(base + 32'(4*i));
        return blk;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch on dut_a and plays the memory: rvalid comes 3 cycles after mem_ren.
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int rrdy_wait,
                         input bit flush_lookup, input bit flush_rvalid, input string tag);
        int cyc, ren_cnt, ren_first, since;
        bit got;
        rreq = 1'b1; addr = a; rrdy = (rrdy_wait == 0);
        cyc = 0; ren_cnt = 0; ren_first = -1; since = -1; got = 1'b0;
        while (!got && cyc < 60) begin
            step();
            cyc++;
            flush  = 1'b0;
            rvalid = 1'b0;
            if (a_valid) begin
                got = 1'b1;
                rreq = 1'b0;
                chk({tag, "_data"}, a_out, memword(a));
            end
            if (a_ren !== 4'h0) begin
                ren_cnt++;
                if (ren_first < 0) begin
                    ren_first = cyc;
                    chk({tag, "_ren"}, {28'h0, a_ren}, 32'hF);
                    chk({tag, "_raddr"}, a_raddr, {a[31:4], 4'h0});
                    exp_raddr = {a[31:4], 4'h0};
                end
                since = 0;
            end else if (since >= 0) begin
                since++;
                if (since == 3) begin
                    rvalid  = 1'b1;
                    a_rdata = mk_block(a_raddr, 4)[127:0];
                    b_rdata = mk_block(b_raddr, 8);
                    if (flush_rvalid) flush = 1'b1;
                end
            end
            if (flush_lookup && cyc == 1) flush = 1'b1;
            if (cyc == rrdy_wait) rrdy = 1'b1;
        end
        chk({tag, "_timeout"}, {31'h0, got}, 32'h1);
        chk({tag, "_ren_count"}, ren_cnt, exp_miss ? 32'd1 : 32'd0);
        if (exp_miss) begin
            chk({tag, "_ren_cycle"}, ren_first, (rrdy_wait < 3) ? 32'd3 : 32'(rrdy_wait + 1));
            exp_m++;
        end else begin
            chk({tag, "_hit_latency"}, cyc, 32'd2);
            exp_h++;
        end
        rreq = 1'b0; rrdy = 1'b0; flush = 1'b0; rvalid = 1'b0;
        step();
        chk({tag, "_valid_pulse"}, {31'h0, a_valid}, 32'h0);
        chk({tag, "_raddr_hold"}, a_raddr, exp_raddr);
        chk({tag, "_hit_cnt"}, a_hit, PERF ? 32'(exp_h) : 32'h0);
        chk({tag, "_miss_cnt"}, a_miss, PERF ? 32'(exp_m) : 32'h0);
    endtask

    initial begin
        int cyc, since;
        bit a_seen, b_seen, a_got, b_got;
        rst_n = 1'b0; rreq = 1'b0; flush = 1'b0; rrdy = 1'b0; rvalid = 1'b0;
        addr = '0; a_rdata = '0; b_rdata = '0;
        #2;
        chk("rst_a_valid", {31'h0, a_valid}, 32'h0);
        chk("rst_a_out",   a_out, 32'h0);
        chk("rst_a_ren",   {28'h0, a_ren}, 32'h0);
        chk("rst_a_raddr", a_raddr, 32'h0);
        chk("rst_a_hit",   a_hit, 32'h0);
        chk("rst_a_miss",  a_miss, 32'h0);
        chk("rst_b_valid", {31'h0, b_valid}, 32'h0);
        chk("rst_b_raddr", b_raddr, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        fetch(32'h0000_1004, 1'b1, 0, 1'b0, 1'b0, "cold_1004");
        fetch(32'h0000_1008, 1'b0, 0, 1'b0, 1'b0, "hit_1008");
        fetch(32'h0000_5000, 1'b1, 0, 1'b0, 1'b0, "miss_5000");
        fetch(32'h0000_1000, 1'b0, 0, 1'b0, 1'b0, "hit_1000_a");
        fetch(32'h0000_9000, 1'b1, 0, 1'b0, 1'b0, "evict_5000");
        fetch(32'h0000_1000, 1'b0, 0, 1'b0, 1'b0, "hit_1000_b");
        fetch(32'h0000_9000, 1'b0, 0, 1'b0, 1'b0, "hit_9000");
        fetch(32'h0000_5000, 1'b1, 0, 1'b0, 1'b0, "remiss_5000");
        fetch(32'h0000_2040, 1'b1, 7, 1'b0, 1'b0, "rrdy_stall");
        fetch(32'h0000_2044, 1'b0, 0, 1'b0, 1'b0, "hit_2044");
        fetch(32'h0000_3000, 1'b1, 0, 1'b0, 1'b1, "flush_rvalid");
        fetch(32'h0000_3000, 1'b1, 0, 1'b0, 1'b0, "refetch_3000");
        fetch(32'h0000_9000, 1'b1, 0, 1'b0, 1'b0, "post_flush_9000");
        fetch(32'h0000_3004, 1'b1, 0, 1'b1, 1'b0, "flush_lookup");
        fetch(32'h0000_3008, 1'b0, 0, 1'b0, 1'b0, "hit_3008");

        // Reset both instances, start a miss on each, then pull reset while they sit in REFILL.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_h = 0; exp_m = 0;
        rreq = 1'b1; addr = 32'h0000_7014; rrdy = 1'b1;
        repeat (3) step();
        chk("rr_a_ren",   {28'h0, a_ren}, 32'hF);
        chk("rr_b_ren",   {28'h0, b_ren}, 32'hF);
        chk("rr_a_raddr", a_raddr, 32'h0000_7010);
        chk("rr_b_raddr", b_raddr, 32'h0000_7000);
        rreq = 1'b0; rrdy = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rr_async_a_raddr", a_raddr, 32'h0);
        chk("rr_async_b_raddr", b_raddr, 32'h0);
        step();
        rst_n = 1'b1;
        rvalid = 1'b1;
        a_rdata = mk_block(32'h0000_7010, 4)[127:0];
        b_rdata = mk_block(32'h0000_7000, 8);
        step();
        rvalid = 1'b0;
        chk("rr_late_a_valid", {31'h0, a_valid}, 32'h0);
        chk("rr_late_b_valid", {31'h0, b_valid}, 32'h0);
        step();
        chk("rr_idle_a_valid", {31'h0, a_valid}, 32'h0);
        chk("rr_idle_b_valid", {31'h0, b_valid}, 32'h0);

        // Refetch: neither instance may have kept the abandoned line.
        rreq = 1'b1; addr = 32'h0000_7014; rrdy = 1'b1;
        cyc = 0; since = -1; a_seen = 1'b0; b_seen = 1'b0; a_got = 1'b0; b_got = 1'b0;
        while (!(a_got && b_got) && cyc < 40) begin
            step();
            cyc++;
            rvalid = 1'b0;
            if (a_ren !== 4'h0) a_seen = 1'b1;
            if (b_ren !== 4'h0) b_seen = 1'b1;
            if (a_valid) begin a_got = 1'b1; chk("rf_a_data", a_out, memword(32'h0000_7014)); end
            if (b_valid) begin b_got = 1'b1; chk("rf_b_data", b_out, memword(32'h0000_7014)); end
            if (a_got || b_got) rreq = 1'b0;
            if (a_ren !== 4'h0 || b_ren !== 4'h0) begin
                since = 0;
            end else if (since >= 0) begin
                since++;
                if (since == 2) begin
                    rvalid  = 1'b1;
                    a_rdata = mk_block(a_raddr, 4)[127:0];
                    b_rdata = mk_block(b_raddr, 8);
                end
            end
        end
        rreq = 1'b0; rrdy = 1'b0; rvalid = 1'b0;
        chk("rf_a_done",   {31'h0, a_got}, 32'h1);
        chk("rf_b_done",   {31'h0, b_got}, 32'h1);
        chk("rf_a_missed", {31'h0, a_seen}, 32'h1);
        chk("rf_b_missed", {31'h0, b_seen}, 32'h1);
        chk("rf_b_raddr",  b_raddr, 32'h0000_7000);
        chk("rf_a_miss_cnt", a_miss, PERF ? 32'h1 : 32'h0);
        chk("rf_b_miss_cnt", b_miss, PERF ? 32'h1 : 32'h0);
        chk("rf_b_hit_cnt",  b_hit, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
